// File: rtl/seg_pkg.sv
// seg_pkg: segment type, digit patterns {a..g} and the BCD to 7-segment lookup
package seg_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_BLANK = 7'b0000000;
  function automatic seg_t bcd_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bcd_seg_decode.sv
// bcd_seg_decode: combinational nibble to 7-segment decode; non-BCD nibbles blank
module bcd_seg_decode import seg_pkg::*; (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = bcd_to_seg(nibble);
endmodule

// File: rtl/bcd_mux_display.sv
// bcd_mux_display: multiplexed BCD display driver, tear-free frame commit; LEADING_ZERO_BLANK_EN blanks leading zeros
module bcd_mux_display import seg_pkg::*; #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [6:0]          segment_out,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                frame_tick
);
  localparam int SW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [SW-1:0]       slot_cnt;
  logic [DW-1:0]       digit_idx;
  logic [4*DIGITS-1:0] shadow, disp;
  logic                pending, slot_end, frame_end, blank;
  logic [3:0]          nib;
  logic [6:0]          seg, seg_d;
  assign slot_end  = slot_cnt == SW'(REFRESH_DIV - 1);
  assign frame_end = slot_end && digit_idx == DW'(DIGITS - 1);
  assign blank     = slot_cnt < SW'(BLANK_CYCLES);
  assign in_ready  = !pending;
  // select the nibble of the digit currently being scanned
  always_comb begin
    nib = 4'd0;
    for (int k = 0; k < DIGITS; k++) if (digit_idx == DW'(k)) nib = disp[4*k +: 4];
  end
  bcd_seg_decode u_dec (.nibble(nib), .seg(seg));
`ifdef LEADING_ZERO_BLANK_EN
  logic lz_blank, upper_zero;
  // a digit above 0 is blanked when it and every more significant digit are zero
  always_comb begin
    lz_blank   = 1'b0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      upper_zero = upper_zero && disp[4*k +: 4] == 4'd0;
      if (digit_idx == DW'(k)) lz_blank = upper_zero;
    end
  end
  assign seg_d = lz_blank ? SEG_BLANK : seg;
`else
  assign seg_d = seg;
`endif
  // slot and digit scan counters
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) digit_idx <= digit_idx == DW'(DIGITS - 1) ? '0 : digit_idx + 1'b1;
    end
  // accept into shadow, commit shadow to the display only at frame end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else if (in_valid && in_ready) begin
      shadow  <= bcd_in;
      pending <= 1'b1;
    end else if (frame_end && pending) begin
      disp    <= shadow;
      pending <= 1'b0;
    end
  // registered outputs, dark during the ghost-suppression gap
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      segment_out <= SEG_BLANK;
      digit_sel   <= '0;
      frame_tick  <= 1'b0;
    end else begin
      segment_out <= blank ? SEG_BLANK : seg_d;
      digit_sel   <= blank ? '0 : DIGITS'(1) << digit_idx;
      frame_tick  <= frame_end;
    end
endmodule

// File: tb/tb_bcd_mux_display.sv
// tb_bcd_mux_display: directed checks of scan, handshake, frame commit and async reset
module tb_bcd_mux_display;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, frame_tick;
  logic [6:0]  segment_out;
  logic [3:0]  digit_sel;
  int          checks = 0, failures = 0, cyc = 0;
  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, BL = 7'b0000000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = S0;
`endif
  bcd_mux_display #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clock(clock), .reset_n(reset_n), .bcd_in(bcd_in), .in_valid(in_valid),
    .in_ready(in_ready), .segment_out(segment_out), .digit_sel(digit_sel), .frame_tick(frame_tick)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask
  task automatic check_frame(input logic [6:0] s3, s2, s1, s0, input int stop);
    logic [6:0] segs [4];
    int s;
    segs = '{s0, s1, s2, s3};
    do begin
      step();
      s = (cyc - 1) % 16;
      check("digit_sel", digit_sel, (s % 4 == 0) ? 0 : (1 << (s / 4)));
      check("segment_out", segment_out, (s % 4 == 0) ? 7'd0 : segs[s / 4]);
      check("frame_tick", frame_tick, s == 15);
    end while (cyc % 16 != stop);
  endtask
  task automatic load(input logic [15:0] w);
    bcd_in = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ready_after_load", in_ready, 1'b0);
  endtask
  initial begin
    step();
    step();
    check("rst_seg", segment_out, 7'd0);
    check("rst_sel", digit_sel, 4'd0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
    reset_n = 1'b1;
    cyc = 0;
    check_frame(S0, S0, S0, S0, 0);
    check_frame(S0, S0, S0, S0, 5);
    load(16'h1234);
    check_frame(S0, S0, S0, S0, 15);
    check("ready_pending", in_ready, 1'b0);
    check_frame(S0, S0, S0, S0, 0);
    check("ready_commit", in_ready, 1'b1);
    check_frame(S1, S2, S3, S4, 0);
    bcd_in = 16'h5678;
    in_valid = 1'b1;
    step();
    bcd_in = 16'h9999;
    check("ready_5678", in_ready, 1'b0);
    check_frame(S1, S2, S3, S4, 0);
    check("ready_5678_commit", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("ready_9999", in_ready, 1'b0);
    check_frame(S5, S6, S7, S8, 0);
    check_frame(S9, S9, S9, S9, 0);
    load(16'h0000);
    check_frame(S9, S9, S9, S9, 0);
    check_frame(LZ, LZ, LZ, S0, 0);
    load(16'h00AF);
    check_frame(LZ, LZ, LZ, S0, 0);
    bcd_in = 16'h5678;
    in_valid = 1'b1;
    check_frame(LZ, LZ, BL, BL, 15);
    in_valid = 1'b0;
    check("ready_before_rst", in_ready, 1'b0);
    reset_n = 1'b0;
    #1;
    check("arst_seg", segment_out, 7'd0);
    check("arst_sel", digit_sel, 4'd0);
    check("arst_tick", frame_tick, 1'b0);
    check("arst_ready", in_ready, 1'b1);
    step();
    reset_n = 1'b1;
    cyc = 0;
    check_frame(LZ, LZ, LZ, S0, 0);
    check("ready_after_rst", in_ready, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
